// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the port-mapped 8N1 UART receiver.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 5208;
  localparam int unsigned PORT_W           = 16;
  localparam int unsigned COUNT_FIELD_W    = 4;

  localparam int unsigned ST_NOT_EMPTY   = 0;
  localparam int unsigned ST_FULL        = 1;
  localparam int unsigned ST_OVERRUN     = 2;
  localparam int unsigned ST_FRAMING_ERR = 3;
  localparam int unsigned ST_PARITY_ERR  = 4;
  localparam int unsigned ST_COUNT_LSB   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } rx_state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic pbit);
    return ~(^{data, pbit});
  endfunction
`endif

endpackage

// File: rtl/uart_rx_port_if.sv
// Processor-side port bundle of the UART receiver: serial line, read strobes, read data, interrupt.
interface uart_rx_port_if;
  logic        rx;
  logic        rd_data;
  logic        rd_status;
  logic        int_ack;
  logic [15:0] in_port;
  logic        interrupt;

  modport slave (
    input  rx, rd_data, rd_status, int_ack,
    output in_port, interrupt
  );

  modport master (
    output rx, rd_data, rd_status, int_ack,
    input  in_port, interrupt
  );
endinterface

// File: rtl/uart_rx_port_fifo.sv
// Small synchronous byte FIFO; a push on a full FIFO is accepted only when a pop frees the head slot.
module rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // When full, a simultaneous push overwrites the slot being popped, which is the correct tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// Port-mapped 8N1 serial receiver with byte FIFO, sticky error flags and a level interrupt.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_port
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_port_if.slave  bus
);

  localparam int unsigned CNT_W      = $clog2(BAUD_DIV);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

  logic [1:0]            sync_q;
  logic                  rx_s;
  rx_state_t             state_q;
  rx_state_t             state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            bit_q;
  logic [7:0]            shift_q;
  logic                  cnt_zero;

  logic                  load_half_c;
  logic                  load_full_c;
  logic                  shift_c;
  logic                  stop_sample_c;
  logic                  push_req_c;
  logic                  frame_bad_c;
  logic                  pop_c;
  logic                  push_ok_c;
  logic                  overrun_set_c;
  logic                  error_set_c;
  logic                  status_clr_c;

  logic                  overrun_q;
  logic                  framing_err_q;
  logic                  interrupt_q;

  logic [7:0]            head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PORT_W-1:0]     status_c;

`ifdef UART_RX_PARITY_EN
  logic                  parity_sample_c;
  logic                  parity_bad_c;
  logic                  parity_err_q;
`endif

  // Synchroniser resets high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_s) state_d = S_START;
      S_START:  if (cnt_zero) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt_zero && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_zero) state_d = S_STOP;
`endif
      S_STOP:   if (cnt_zero) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_half_c   = 1'b0;
    load_full_c   = 1'b0;
    shift_c       = 1'b0;
    stop_sample_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_sample_c = 1'b0;
`endif
    case (state_q)
      S_IDLE:  load_half_c = !rx_s;
      S_START: load_full_c = cnt_zero && !rx_s;
      S_DATA: begin
        shift_c     = cnt_zero;
        load_full_c = cnt_zero;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        parity_sample_c = cnt_zero;
        load_full_c     = cnt_zero;
      end
`endif
      S_STOP:  stop_sample_c = cnt_zero;
      default: ;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (load_half_c) begin
        cnt_q <= HALF_LOAD;
        bit_q <= '0;
      end else if (load_full_c) begin
        cnt_q <= FULL_LOAD;
      end else if (!cnt_zero) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (shift_c) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  assign status_clr_c  = bus.rd_status && !bus.rd_data;
  assign pop_c         = bus.rd_data && !fifo_empty;
  assign push_req_c    = stop_sample_c && rx_s;
  assign frame_bad_c   = stop_sample_c && !rx_s;
  assign push_ok_c     = push_req_c && (!fifo_full || pop_c);
  assign overrun_set_c = push_req_c && fifo_full && !pop_c;

`ifdef UART_RX_PARITY_EN
  assign parity_bad_c = parity_sample_c && !even_parity_ok(shift_q, rx_s);
  assign error_set_c  = overrun_set_c || frame_bad_c || parity_bad_c;
`else
  assign error_set_c  = overrun_set_c || frame_bad_c;
`endif

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FIFO_CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok_c),
    .pop   (pop_c),
    .din   (shift_q),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flags: a set event on the clearing edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      interrupt_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      overrun_q     <= (overrun_q && !status_clr_c) || overrun_set_c;
      framing_err_q <= (framing_err_q && !status_clr_c) || frame_bad_c;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= (parity_err_q && !status_clr_c) || parity_bad_c;
`endif
      if (push_ok_c || error_set_c) begin
        interrupt_q <= 1'b1;
      end else if (bus.int_ack) begin
        interrupt_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status_c                                   = '0;
    status_c[ST_NOT_EMPTY]                     = !fifo_empty;
    status_c[ST_FULL]                          = fifo_full;
    status_c[ST_OVERRUN]                       = overrun_q;
    status_c[ST_FRAMING_ERR]                   = framing_err_q;
`ifdef UART_RX_PARITY_EN
    status_c[ST_PARITY_ERR]                    = parity_err_q;
`endif
    status_c[ST_COUNT_LSB +: COUNT_FIELD_W]    = COUNT_FIELD_W'(fifo_count);
  end

  assign bus.in_port   = bus.rd_data   ? {8'h00, (fifo_empty ? 8'h00 : head)} :
                         bus.rd_status ? status_c : '0;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: frame-level reference model (byte queue + flags keyed on predicted
// push edges), per-cycle compare of in_port/interrupt, directed cases and random traffic.
module tb_uart_rx_port;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 3 + BD / 2 + 9 * BD;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic rx        = 1'b1;
  logic rd_data   = 1'b0;
  logic rd_status = 1'b0;
  logic int_ack   = 1'b0;

  uart_rx_port_if bus ();
  assign bus.rx        = rx;
  assign bus.rd_data   = rd_data;
  assign bus.rd_status = rd_status;
  assign bus.int_ack   = int_ack;

  uart_rx_port #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Reference model state.
  int         cyc       = 0;
  int         last_rst  = 0;
  logic [7:0] mq[$];
  bit         m_ov      = 1'b0;
  bit         m_fe      = 1'b0;
  bit         m_int     = 1'b0;

  // Frame currently on the line, written by the serial driver.
  int         pend_cyc  = -1;
  int         pend_fall = -1;
  logic [7:0] pend_b    = 8'h00;
  bit         pend_bad  = 1'b0;
  int         next_ok   = 0;

  // Hand-computed literal checks requested by the directed sequence.
  int          lit_seq  = 0;
  int          lit_done = 0;
  string       lit_tag  = "";
  logic [15:0] lit_in   = 16'h0000;
  bit          lit_use_int = 1'b0;
  bit          lit_int  = 1'b0;

  bit done = 1'b0;

  always @(posedge clk) begin : model
    bit pop_m, clr_m, acc_m, ov_m, fe_m;
    cyc = cyc + 1;
    if (!rst) begin
      mq.delete();
      m_ov = 1'b0; m_fe = 1'b0; m_int = 1'b0;
      last_rst = cyc;
    end else begin
      pop_m = rd_data && (mq.size() != 0);
      clr_m = rd_status && !rd_data;
      acc_m = 1'b0; ov_m = 1'b0; fe_m = 1'b0;
      if (cyc == pend_cyc && pend_fall > last_rst) begin
        if (pend_bad) fe_m = 1'b1;
        else if (mq.size() < DEPTH || pop_m) acc_m = 1'b1;
        else ov_m = 1'b1;
      end
      if (pop_m) void'(mq.pop_front());
      if (acc_m) mq.push_back(pend_b);
      m_ov = (m_ov && !clr_m) || ov_m;
      m_fe = (m_fe && !clr_m) || fe_m;
      if (acc_m || ov_m || fe_m) m_int = 1'b1;
      else if (int_ack) m_int = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] e_in;
    if (chk_en) begin
      if (rd_data)
        e_in = {8'h00, (mq.size() != 0) ? mq[0] : 8'h00};
      else if (rd_status)
        e_in = {4'h0, 4'(mq.size()), 3'b000, 1'b0, m_fe, m_ov,
                1'(mq.size() == DEPTH), 1'(mq.size() != 0)};
      else
        e_in = 16'h0000;
      vectors++;
      if (bus.in_port !== e_in) begin
        errors++;
        $display("FAIL in_port cyc=%0d got %h want %h", cyc, bus.in_port, e_in);
      end
      vectors++;
      if (bus.interrupt !== m_int) begin
        errors++;
        $display("FAIL interrupt cyc=%0d got %b want %b", cyc, bus.interrupt, m_int);
      end
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      vectors++;
      if (bus.in_port !== lit_in) begin
        errors++;
        $display("FAIL %s in_port got %h want %h", lit_tag, bus.in_port, lit_in);
      end
      if (lit_use_int) begin
        vectors++;
        if (bus.interrupt !== lit_int) begin
          errors++;
          $display("FAIL %s interrupt got %b want %b", lit_tag, bus.interrupt, lit_int);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic strobe(input bit d, input bit s, input bit a);
    rd_data = d; rd_status = s; int_ack = a;
  endtask

  task automatic lit(input string tag, input logic [15:0] ein, input bit use_int, input bit eint);
    lit_tag = tag; lit_in = ein; lit_use_int = use_int; lit_int = eint;
    lit_seq++;
  endtask

  // Drives one frame; returns at the start of a good stop bit, or after a bad one.
  task automatic send(input logic [7:0] b, input bit bad_stop, input int rst_at);
    logic [8:0] bits;
    int k;
    wait_cyc(next_ok);
    k = cyc;
    bits = {b, 1'b0};
    pend_b = b; pend_bad = bad_stop; pend_fall = k; pend_cyc = k + FRAME;
    for (int j = 0; j < 9; j++) begin
      rx = bits[j];
      for (int c = 0; c < BD; c++) begin
        if (rst_at > 0 && j * BD + c == rst_at) rst = 1'b0;
        if (rst_at > 0 && j * BD + c == rst_at + 3) rst = 1'b1;
        tick();
      end
    end
    rx = ~bad_stop;
    if (bad_stop) begin
      repeat (BD) tick();
      rx = 1'b1;
    end
    next_ok = k + 10 * BD;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int k;
    repeat (3) tick();
    strobe(0, 1, 0); lit("reset", 16'h0000, 1, 0);
    tick();
    strobe(0, 0, 0); rst = 1'b1; chk_en = 1'b1;
    next_ok = cyc + 4;

    // Single byte and exact push latency.
    send(8'hA5, 0, 0); k = pend_fall;
    wait_cyc(k + FRAME - 1); strobe(0, 1, 0); lit("t1_before_push", 16'h0000, 1, 0);
    tick(); lit("t1_status", 16'h0101, 1, 1);
    tick(); strobe(1, 0, 0); lit("t1_data", 16'h00A5, 1, 1);
    tick(); strobe(0, 1, 0); lit("t1_status_empty", 16'h0000, 1, 1);
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0); lit("t1_ack", 16'h0000, 1, 0);

    // Overrun on the fifth byte.
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 0);
    wait_cyc(pend_fall + FRAME); strobe(0, 1, 0); lit("t2_status", 16'h0407, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(); strobe(1, 0, 0); lit("t2_pop", {8'h00, 8'(i)}, 0, 0);
    end
    tick(); strobe(0, 1, 0); lit("t2_status2", 16'h0000, 0, 0);
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0);

    // False start.
    wait_cyc(next_ok);
    rx = 1'b0; repeat (6) tick(); rx = 1'b1;
    repeat (40) tick(); next_ok = cyc;
    strobe(0, 1, 0); lit("t3_false_start", 16'h0000, 1, 0);
    tick(); strobe(0, 0, 0);

    // Framing error and interrupt acknowledge.
    send(8'h3C, 1, 0);
    strobe(0, 1, 0); lit("t4_status", 16'h0008, 1, 1);
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0); lit("t4_ack", 16'h0000, 1, 0);

    // Push and pop on the same edge while full; ack on a push edge.
    for (int i = 1; i <= 4; i++) send(8'(i * 16), 0, 0);
    wait_cyc(pend_fall + FRAME);
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0);
    send(8'h50, 0, 0); k = pend_fall;
    wait_cyc(k + FRAME - 1); strobe(1, 0, 1); lit("t5_pop_on_push", 16'h0010, 1, 0);
    tick(); strobe(0, 1, 0); lit("t5_status", 16'h0403, 1, 1);
    for (int i = 2; i <= 5; i++) begin
      tick(); strobe(1, 0, 0); lit("t5_drain", {8'h00, 8'(i * 16)}, 0, 0);
    end
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0);

    // Reset during data bit 4, then a clean frame.
    send(8'h11, 0, 0);
    wait_cyc(pend_cyc + 1);
    send(8'hF0, 0, 84);
    strobe(0, 1, 0); lit("t6_after_reset", 16'h0000, 1, 0);
    tick(); strobe(0, 0, 0);
    send(8'h7E, 0, 0);
    wait_cyc(pend_fall + FRAME); strobe(0, 1, 0); lit("t6_status", 16'h0101, 1, 1);
    tick(); strobe(1, 0, 0); lit("t6_data", 16'h007E, 1, 1);
    tick(); strobe(0, 0, 1);
    tick(); strobe(0, 0, 0);

    // Random traffic with concurrent random reads and acknowledges.
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          next_ok = next_ok + int'($urandom_range(0, 24));
          send(8'($urandom), $urandom_range(0, 5) == 0, 0);
        end
        done = 1'b1;
      end
      begin
        int r;
        while (!done) begin
          r = int'($urandom_range(0, 99));
          rd_data   = (r < 20) || (r >= 97);
          rd_status = (r >= 20 && r < 32) || (r >= 97);
          int_ack   = (r >= 32 && r < 42);
          tick();
        end
        strobe(0, 0, 0);
      end
    join

    wait_cyc(pend_cyc + 1);
    repeat (DEPTH + 1) begin
      strobe(1, 0, 0); tick();
    end
    strobe(0, 1, 0); tick();
    strobe(0, 0, 1); tick();
    strobe(0, 0, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
